game_ctrl: RTL

- Game-flow controller for the VGA bouncing-box/paddle game.
- Sequences the box/board datapath through attract, serve, play and game-over phases.
- Counts score and lives, scales ball speed with hit count, and gates box motion via game_run.
- Sits between the VGA timing generator (frame_tick), the buttons, and the box/board motion and collision logic.

---
 rtl/game_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl
// Description : Game-flow controller for the VGA bouncing-box/paddle game.
//               Tracks attract/serve/play/game-over phases, score, lives,
//               and ball speed.
// Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl #(
    parameter int LIVES           = 3,
    parameter int SCORE_W         = 16,
    parameter int SERVE_FRAMES    = 60,
    parameter int OVER_FRAMES     = 180,
    parameter int SPEED_STEP_HITS = 5,
    parameter int MAX_SPEED       = 4,
    parameter int BLINK_FRAMES    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               btn_start,
    input  logic               hit,
    input  logic               miss,
    output logic               game_run,
    output logic               ball_reload,
    output logic [2:0]         speed,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives,
    output logic [1:0]         state,
    output logic               blink
);

    localparam int c_frame_max = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
    localparam int c_frame_w   = $clog2(c_frame_max + 1);
    localparam int c_hit_w     = $clog2(SPEED_STEP_HITS + 1);
    localparam int c_blink_w   = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t               r_state,  w_state;
    logic [c_frame_w-1:0] r_frame_cnt, w_frame_cnt, w_frame_inc;
    logic [c_hit_w-1:0]   r_hit_cnt,   w_hit_cnt,   w_hit_inc;
    logic [c_blink_w-1:0] r_blink_cnt, w_blink_cnt, w_blink_inc;
    logic                 r_btn_prev;
    logic                 r_game_run,  w_game_run;
    logic                 r_ball_reload, w_ball_reload;
    logic [2:0]           r_speed,  w_speed;
    logic [SCORE_W-1:0]   r_score,  w_score;
    logic [3:0]           r_lives,  w_lives;
    logic                 r_blink,  w_blink;
    logic                 w_start_press;

    // Falling edge of the active-low button; holding it low gives one press.
    assign w_start_press = r_btn_prev & ~btn_start;
    assign w_frame_inc   = r_frame_cnt + 1'b1;
    assign w_hit_inc     = r_hit_cnt + 1'b1;
    assign w_blink_inc   = r_blink_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_frame_cnt   <= '0;
            r_hit_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_btn_prev    <= 1'b1;
            r_game_run    <= 1'b0;
            r_ball_reload <= 1'b0;
            r_speed       <= 3'd1;
            r_score       <= '0;
            r_lives       <= 4'd0;
            r_blink       <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_frame_cnt   <= w_frame_cnt;
            r_hit_cnt     <= w_hit_cnt;
            r_blink_cnt   <= w_blink_cnt;
            r_btn_prev    <= btn_start;
            r_game_run    <= w_game_run;
            r_ball_reload <= w_ball_reload;
            r_speed       <= w_speed;
            r_score       <= w_score;
            r_lives       <= w_lives;
            r_blink       <= w_blink;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_frame_cnt   = r_frame_cnt;
        w_hit_cnt     = r_hit_cnt;
        w_blink_cnt   = r_blink_cnt;
        w_ball_reload = 1'b0;
        w_speed       = r_speed;
        w_score       = r_score;
        w_lives       = r_lives;
        w_blink       = r_blink;

        case (r_state)
            ST_IDLE: begin
                if (w_start_press) begin
                    w_state       = ST_SERVE;
                    w_frame_cnt   = '0;
                    w_hit_cnt     = '0;
                    w_score       = '0;
                    w_lives       = 4'(LIVES);
                    w_speed       = 3'd1;
                    w_ball_reload = 1'b1;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (w_frame_inc == c_frame_w'(SERVE_FRAMES)) begin
                        w_state     = ST_PLAY;
                        w_frame_cnt = '0;
                    end else begin
                        w_frame_cnt = w_frame_inc;
                    end
                end
            end
            ST_PLAY: begin
                // A miss in the same cycle as a hit discards the hit.
                if (miss) begin
                    w_frame_cnt = '0;
                    if (r_lives > 4'd1) begin
                        w_lives       = r_lives - 4'd1;
                        w_state       = ST_SERVE;
                        w_ball_reload = 1'b1;
                    end else begin
                        w_lives     = 4'd0;
                        w_state     = ST_OVER;
                        w_blink     = 1'b1;
                        w_blink_cnt = '0;
                    end
                end else if (hit) begin
                    w_score = (&r_score) ? r_score : r_score + 1'b1;
                    if (w_hit_inc == c_hit_w'(SPEED_STEP_HITS)) begin
                        w_hit_cnt = '0;
                        w_speed   = (r_speed < 3'(MAX_SPEED)) ? r_speed + 3'd1 : r_speed;
                    end else begin
                        w_hit_cnt = w_hit_inc;
                    end
                end
            end
            ST_OVER: begin
                if (frame_tick) begin
                    if (w_frame_inc == c_frame_w'(OVER_FRAMES)) begin
                        w_state     = ST_IDLE;
                        w_frame_cnt = '0;
                        w_blink_cnt = '0;
                        w_blink     = 1'b0;
                    end else begin
                        w_frame_cnt = w_frame_inc;
                        if (w_blink_inc == c_blink_w'(BLINK_FRAMES)) begin
                            w_blink_cnt = '0;
                            w_blink     = ~r_blink;
                        end else begin
                            w_blink_cnt = w_blink_inc;
                        end
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase

        w_game_run = (w_state == ST_PLAY);
    end

    assign game_run    = r_game_run;
    assign ball_reload = r_ball_reload;
    assign speed       = r_speed;
    assign score       = r_score;
    assign lives       = r_lives;
    assign state       = r_state;
    assign blink       = r_blink;

endmodule
`default_nettype wire
